// File: rtl/rmon_counters_if.sv
// ---------------------------------------------------------------------------
// rmon_counters_if
//   Four-phase read port between a management reader and rmon_counters.
//
//   rd_req_i   reader -> block   read request, held until rd_ack_o is seen
//   rd_addr_i  reader -> block   counter index, stable while rd_req_i=1
//   rd_clr_i   reader -> block   clear-on-read, sampled with rd_req_i
//   rd_ack_o   block  -> reader  read acknowledge
//   rd_data_o  block  -> reader  captured counter value
//   rd_ovf_o   block  -> reader  captured overflow flag
//
//   master: the management reader.  slave: the counter block.
// ---------------------------------------------------------------------------
interface rmon_counters_if #(
  parameter int g_addr_width = 4,
  parameter int g_cnt_width  = 32
);
  logic                    rd_req_i;
  logic [g_addr_width-1:0] rd_addr_i;
  logic                    rd_clr_i;
  logic                    rd_ack_o;
  logic [g_cnt_width-1:0]  rd_data_o;
  logic                    rd_ovf_o;

  modport master (
    output rd_req_i, rd_addr_i, rd_clr_i,
    input  rd_ack_o, rd_data_o, rd_ovf_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, rd_clr_i,
    output rd_ack_o, rd_data_o, rd_ovf_o
  );
endinterface

// File: rtl/rmon_counters.sv
// ---------------------------------------------------------------------------
// rmon_counters
//   Receiving end of the RMON event-trigger interface. Each trigger line is
//   rising-edge detected and counted in its own counter; a sticky overflow
//   flag records a counter rolling past its maximum. A four-phase read port
//   returns one counter (with optional clear-on-read) per handshake.
//
//   clk_i      system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   trig_i     event triggers, one bit per counter
//   clr_all_i  synchronous clear of every counter and overflow flag
//   rd         read port (rmon_counters_if.slave)
//   ovf_o      sticky per-channel overflow flags
// ---------------------------------------------------------------------------
module rmon_counters #(
  parameter int g_trig_width = 10,
  parameter int g_cnt_width  = 32,
  parameter int g_addr_width = 4,
  parameter int g_wrap       = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [g_trig_width-1:0] trig_i,
  input  logic                    clr_all_i,
  rmon_counters_if.slave          rd,
  output logic [g_trig_width-1:0] ovf_o
);

  localparam logic [g_cnt_width-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t                  state;
  logic [g_trig_width-1:0] trig_d;
  logic [g_trig_width-1:0] ovf;
  logic [g_cnt_width-1:0]  cnt [g_trig_width];

  logic [g_trig_width-1:0] ev;
  logic                    capture;
  logic [g_cnt_width-1:0]  sel_cnt;
  logic                    sel_ovf;
  logic [g_trig_width-1:0] clr_hit;

  assign ev      = trig_i & ~trig_d;
  assign capture = (state == S_IDLE) && rd.rd_req_i;
  assign ovf_o   = ovf;

  // Read mux and clear-on-read decode. An address that matches no channel
  // leaves the defaults in place: data 0, flag 0, nothing cleared.
  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a signal unassigned and no latch is inferred.
    sel_cnt = '0;
    sel_ovf = 1'b0;
    clr_hit = '0;
    for (int i = 0; i < g_trig_width; i++) begin
      if (rd.rd_addr_i == g_addr_width'(i)) begin
        sel_cnt    = cnt[i];
        sel_ovf    = ovf[i];
        clr_hit[i] = capture && rd.rd_clr_i;
      end
    end
  end

  // Edge detect and counter update. A clear wins over a coincident event but
  // keeps it: the counter restarts at 1 so no event is lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the counters are flip-flops, not a RAM, so each entry is reset
      // explicitly; software expects zeroed counters after reset.
      for (int i = 0; i < g_trig_width; i++) begin
        cnt[i] <= '0;
      end
      ovf    <= '0;
      trig_d <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic, so every
      // read of cnt/ovf/trig_d in this edge sees the pre-edge value.
      trig_d <= trig_i;
      for (int i = 0; i < g_trig_width; i++) begin
        if (clr_all_i || clr_hit[i]) begin
          cnt[i] <= g_cnt_width'(ev[i]);
          ovf[i] <= 1'b0;
        end else if (ev[i]) begin
          if (cnt[i] == CNT_MAX) begin
            cnt[i] <= (g_wrap != 0) ? '0 : CNT_MAX;
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Read handshake. Capture happens only on the IDLE->ACK transition, so the
  // address and clear inputs are ignored for the rest of the handshake and
  // the captured values hold until the next request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      rd.rd_ack_o  <= 1'b0;
      rd.rd_data_o <= '0;
      rd.rd_ovf_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd.rd_req_i) begin
            rd.rd_data_o <= sel_cnt;
            rd.rd_ovf_o  <= sel_ovf;
            rd.rd_ack_o  <= 1'b1;
            state        <= S_ACK;
          end
        end
        S_ACK: begin
          if (!rd.rd_req_i) begin
            rd.rd_ack_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          rd.rd_ack_o <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmon_counters.sv
// ---------------------------------------------------------------------------
// tb_rmon_counters
//   Directed bench for rmon_counters. One 32-bit wrapping instance carries
//   most of the sequence; two 4-bit instances (wrap and saturate) share a
//   trigger vector for the overflow cases. Expected read results are pushed
//   to a scoreboard when a request is driven and popped at the acknowledge.
// ---------------------------------------------------------------------------
module tb_rmon_counters;

  localparam int TW  = 10;
  localparam int CW  = 32;
  localparam int AW  = 4;
  localparam int SCW = 4;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] trig = '0;
  logic [TW-1:0] strig = '0;
  logic          clr_all = 1'b0;
  logic [TW-1:0] ovf_m, ovf_w, ovf_s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mdl[TW];

  always #5 clk = ~clk;

  rmon_counters_if #(.g_addr_width(AW), .g_cnt_width(CW))  m_if ();
  rmon_counters_if #(.g_addr_width(AW), .g_cnt_width(SCW)) w_if ();
  rmon_counters_if #(.g_addr_width(AW), .g_cnt_width(SCW)) s_if ();

  rmon_counters #(.g_trig_width(TW), .g_cnt_width(CW), .g_addr_width(AW), .g_wrap(1)) u_main (
    .clk_i(clk), .rst_n_i(rst_n), .trig_i(trig), .clr_all_i(clr_all), .rd(m_if.slave), .ovf_o(ovf_m)
  );
  rmon_counters #(.g_trig_width(TW), .g_cnt_width(SCW), .g_addr_width(AW), .g_wrap(1)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .trig_i(strig), .clr_all_i(clr_all), .rd(w_if.slave), .ovf_o(ovf_w)
  );
  rmon_counters #(.g_trig_width(TW), .g_cnt_width(SCW), .g_addr_width(AW), .g_wrap(0)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .trig_i(strig), .clr_all_i(clr_all), .rd(s_if.slave), .ovf_o(ovf_s)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic req, input int addr, input logic clr);
    case (which)
      0: begin m_if.rd_req_i = req; m_if.rd_addr_i = AW'(addr); m_if.rd_clr_i = clr; end
      1: begin w_if.rd_req_i = req; w_if.rd_addr_i = AW'(addr); w_if.rd_clr_i = clr; end
      default: begin s_if.rd_req_i = req; s_if.rd_addr_i = AW'(addr); s_if.rd_clr_i = clr; end
    endcase
  endtask

  function automatic logic get_ack(input int which);
    case (which)
      0:       return m_if.rd_ack_o;
      1:       return w_if.rd_ack_o;
      default: return s_if.rd_ack_o;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int which);
    case (which)
      0:       return m_if.rd_data_o;
      1:       return 32'(w_if.rd_data_o);
      default: return 32'(s_if.rd_data_o);
    endcase
  endfunction

  function automatic logic get_ovf(input int which);
    case (which)
      0:       return m_if.rd_ovf_o;
      1:       return w_if.rd_ovf_o;
      default: return s_if.rd_ovf_o;
    endcase
  endfunction

  task automatic drive_trig(input int which, input int ch, input logic v);
    if (which == 0) trig[ch] = v;
    else            strig[ch] = v;
  endtask

  // One-cycle pulse followed by one low cycle.
  task automatic pulse(input int which, input int ch);
    @(negedge clk);
    drive_trig(which, ch, 1'b1);
    @(negedge clk);
    drive_trig(which, ch, 1'b0);
    if (which == 0) mdl[ch]++;
  endtask

  // Full four-phase read. coinc >= 0 raises that trigger together with the
  // request so its edge lands on the capture edge.
  task automatic do_read(input int which, input int addr, input logic clr, input int coinc,
                         input logic [31:0] exp_d, input logic exp_o, input string tag);
    logic got;
    exp_t e;
    sb.push_back('{tag, exp_d, exp_o});
    @(negedge clk);
    set_req(which, 1'b1, addr, clr);
    if (coinc >= 0) drive_trig(which, coinc, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (coinc >= 0) drive_trig(which, coinc, 1'b0);
      got = get_ack(which);
    end
    check({tag, "_ack"}, 64'(got), 64'(1));
    e = sb.pop_front();
    check({e.tag, "_data"}, 64'(get_data(which)), 64'(e.data));
    check({e.tag, "_ovf"}, 64'(get_ovf(which)), 64'(e.ovf));
    set_req(which, 1'b0, addr, 1'b0);
    @(negedge clk);
    check({tag, "_ack_drop"}, 64'(get_ack(which)), 64'(0));
  endtask

  // Read of the main instance with expectations and model update from mdl.
  task automatic main_read(input int addr, input logic clr, input int coinc, input string tag);
    logic [31:0] exp_d;
    exp_d = (addr < TW) ? 32'(mdl[addr]) : 32'd0;
    do_read(0, addr, clr, coinc, exp_d, 1'b0, tag);
    if (clr && addr < TW) mdl[addr] = (coinc == addr) ? 1 : 0;
    if (coinc >= 0 && !(clr && coinc == addr)) mdl[coinc]++;
  endtask

  initial begin
    exp_t e;
    int   ack_cycles;
    for (int i = 0; i < TW; i++) mdl[i] = 0;
    set_req(0, 1'b0, 0, 1'b0);
    set_req(1, 1'b0, 0, 1'b0);
    set_req(2, 1'b0, 0, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(m_if.rd_ack_o), 64'(0));
    check("rst_data", 64'(m_if.rd_data_o), 64'(0));
    check("rst_rd_ovf", 64'(m_if.rd_ovf_o), 64'(0));
    check("rst_ovf_o", 64'(ovf_m), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single pulses.
    for (int k = 0; k < 5; k++) pulse(0, 3);
    for (int k = 0; k < 2; k++) pulse(0, 0);
    main_read(3, 1'b0, -1, "pulse_ch3");
    main_read(0, 1'b0, -1, "pulse_ch0");
    for (int a = 0; a < 16; a++) main_read(a, 1'b0, -1, $sformatf("scan_a%0d", a));

    // Level hold counts once, then one more pulse.
    @(negedge clk);
    trig[1] = 1'b1;
    repeat (50) @(negedge clk);
    trig[1] = 1'b0;
    mdl[1]++;
    @(negedge clk);
    pulse(0, 1);
    main_read(1, 1'b0, -1, "level_ch1");

    // Clear-on-read with an event on the capture edge.
    for (int k = 0; k < 9; k++) pulse(0, 7);
    main_read(7, 1'b1, 7, "cor_ch7");
    main_read(7, 1'b0, -1, "cor_after");
    main_read(12, 1'b1, -1, "oor_a12");

    // Long handshake: six ack cycles, one capture, address change ignored.
    sb.push_back('{"hold", 32'(mdl[3]), 1'b0});
    @(negedge clk);
    set_req(0, 1'b1, 3, 1'b0);
    ack_cycles = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (m_if.rd_ack_o) ack_cycles++;
      if (i == 2) m_if.rd_addr_i = AW'(0);
    end
    check("hold_ack_cycles", 64'(ack_cycles), 64'(6));
    e = sb.pop_front();
    check({e.tag, "_data"}, 64'(m_if.rd_data_o), 64'(e.data));
    set_req(0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("hold_ack_drop", 64'(m_if.rd_ack_o), 64'(0));
    check("hold_data_kept", 64'(m_if.rd_data_o), 64'(e.data));

    // Asynchronous reset during ACK.
    @(negedge clk);
    set_req(0, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("arst_pre_ack", 64'(m_if.rd_ack_o), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("arst_ack", 64'(m_if.rd_ack_o), 64'(0));
    set_req(0, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TW; i++) mdl[i] = 0;
    for (int a = 0; a < TW; a++) main_read(a, 1'b0, -1, $sformatf("arst_a%0d", a));

    // Wrap and saturate on the 4-bit instances.
    for (int k = 0; k < 17; k++) pulse(1, 2);
    do_read(1, 2, 1'b0, -1, 32'd1, 1'b1, "wrap_ch2");
    check("wrap_ovf_o2", 64'(ovf_w[2]), 64'(1));
    do_read(2, 2, 1'b0, -1, 32'd15, 1'b1, "sat_ch2");
    check("sat_ovf_o2", 64'(ovf_s[2]), 64'(1));

    // clr_all with a coincident rising edge on channel 4.
    @(negedge clk);
    trig = '1;
    @(negedge clk);
    trig = '0;
    for (int i = 0; i < TW; i++) mdl[i]++;
    main_read(9, 1'b0, -1, "pre_clr_a9");
    @(negedge clk);
    clr_all = 1'b1;
    trig[4] = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    trig[4] = 1'b0;
    for (int i = 0; i < TW; i++) mdl[i] = 0;
    mdl[4] = 1;
    check("clr_ovf_main", 64'(ovf_m), 64'(0));
    check("clr_ovf_wrap", 64'(ovf_w), 64'(0));
    check("clr_ovf_sat", 64'(ovf_s), 64'(0));
    for (int a = 0; a < TW; a++) main_read(a, 1'b0, -1, $sformatf("clr_a%0d", a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmon_counters.md
# rmon_counters

Synthesizable receiving end of the RMON event-trigger interface. It takes `g_trig_width` single-cycle-or-longer trigger lines, detects rising edges and accumulates one event counter per line. A four-phase request/acknowledge port lets a management reader fetch any counter, with an optional clear-on-read. The block sits between the switch's per-port event sources and the RMON register bank.

## Interface
- `g_trig_width`, 10, number of trigger lines and counters.
- `g_cnt_width`, 32, width of each counter.
- `g_addr_width`, 4, width of the read address; must satisfy 2^`g_addr_width` >= `g_trig_width`.
- `g_wrap`, 1, overflow policy: 1 means the counter wraps to 0, 0 means it saturates at its maximum value.

- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `trig_i`  in  `g_trig_width`  event triggers, synchronous to `clk_i`, one bit per counter.
- `clr_all_i`  in  1  synchronous clear of all counters and overflow flags.
- `rd_req_i`  in  1  read request, four-phase.
- `rd_addr_i`  in  `g_addr_width`  counter index, held stable while `rd_req_i`=1.
- `rd_clr_i`  in  1  clear-on-read, sampled together with `rd_req_i`.
- `rd_ack_o`  out  1  read acknowledge.
- `rd_data_o`  out  `g_cnt_width`  captured counter value.
- `rd_ovf_o`  out  1  captured overflow flag.
- `ovf_o`  out  `g_trig_width`  sticky per-channel overflow flags.

## Operation
- **Edge detect:** register `trig_d` <= `trig_i`. The event for channel n is `trig_i[n]` & ~`trig_d[n]`. A level held high counts once.
- **Counter update per edge, per channel, in priority order:**
  1. Clear: either `clr_all_i`=1, or a clear-on-read hits this channel. The counter becomes 1 if there is a coincident event, otherwise 0. `ovf[n]` becomes 0.
  2. Event with counter below max: counter + 1.
  3. Event with counter at max (2^`g_cnt_width`-1): counter becomes 0 if `g_wrap`=1, or stays at max if `g_wrap`=0. `ovf[n]` becomes 1 in both cases.
  4. Otherwise: hold.
- **Read FSM states:** IDLE, ACK.
  - IDLE, `rd_req_i`=1 sampled:
    - Capture `rd_data_o` = cnt[`rd_addr_i`] and `rd_ovf_o` = ovf[`rd_addr_i`]. These are the pre-update values at that edge.
    - If `rd_clr_i`=1, clear that channel at the same edge, per rule 1.
    - Go to ACK.
  - ACK: `rd_ack_o`=1. Stay while `rd_req_i`=1. When `rd_req_i`=0, go to IDLE.
  - In ACK, `rd_addr_i` and `rd_clr_i` are ignored; there is exactly one capture per handshake.
- **Out-of-range address** (`rd_addr_i` >= `g_trig_width`): the handshake completes normally, `rd_data_o`=0, `rd_ovf_o`=0, and nothing is cleared.
- **Outputs:** `rd_data_o` and `rd_ovf_o` hold their values until the next capture.

## Timing
- **Reset values:** all counters 0, ovf 0, `trig_d` 0, FSM in IDLE, `rd_ack_o` 0, `rd_data_o` 0, `rd_ovf_o` 0, `ovf_o` 0.
- **Reset is asynchronous.** Asserting it mid-handshake drops `rd_ack_o` immediately. After release the FSM is in IDLE; a still-asserted `rd_req_i` starts a new handshake.
- **High trigger at the first edge after reset:** because `trig_d` resets to 0, a `trig_i` bit that is high at the first post-reset edge counts as one event.
- **Event latency:** the counter updates at the edge that first samples `trig_i[n]`=1 with `trig_d[n]`=0.
- **Read latency:**
  - `rd_req_i` sampled high at edge N gives `rd_ack_o`, `rd_data_o` and `rd_ovf_o` valid after edge N.
  - `rd_req_i` sampled low at edge M in ACK gives `rd_ack_o`=0 after edge M.
  - Minimum handshake is 2 cycles; the next request can be sampled at edge M+1.
- **Event coinciding with a read capture:** an event on the read channel at capture edge N is not in `rd_data_o`.
  - Without clear: it appears in the counter after N.
  - With clear: the counter becomes 1. No event is lost.
- **Event coinciding with `clr_all_i`:** the counter becomes 1.
- **`ovf_o`** reflects the registered flags with no extra delay.
- **Input rate:** triggers may assert on consecutive cycles only if they return low in between. Minimum rising-edge spacing is 2 cycles per channel.

## Test plan
- **Reset and single pulses:** reset, then one-cycle pulses on `trig_i[3]` ×5 and `trig_i[0]` ×2, with gaps. Reading address 3 returns 5 with `rd_ovf_o`=0. Reading 0 returns 2. All other addresses return 0.
- **Level hold:** hold `trig_i[1]` high for 50 cycles, then one more pulse. Reading address 1 returns 2.
- **Wrap and saturate:** use `g_cnt_width`=4 and apply 17 pulses on channel 2.
  - `g_wrap`=1: read gives 1, `rd_ovf_o`=1, `ovf_o[2]`=1.
  - `g_wrap`=0: read gives 15, `rd_ovf_o`=1.
- **Clear-on-read with coincident event:**
  - Counter 7 = 9. Request with `rd_clr_i`=1 and a `trig_i[7]` edge at the capture edge: `rd_data_o`=9; a following plain read gives 1.
  - Out-of-range address 12: `rd_data_o`=0 and the ack completes.
- **Handshake protocol:**
  - Hold `rd_req_i` for 6 cycles: `rd_ack_o` high for 6 cycles with a single capture. Changing `rd_addr_i` during ACK leaves `rd_data_o` unchanged.
  - Assert `rst_n_i` low during ACK: `rd_ack_o` goes to 0 immediately and all counters read 0 after release.
- **`clr_all_i` with concurrent events:** with all counters nonzero, pulse `clr_all_i` while `trig_i[4]` rises. Counter 4 reads 1, all others read 0, and `ovf_o`=0.
